serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/adders_pkg.sv | 13 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 3 files changed

// File: rtl/adders_pkg.sv
// Shared constants for the adder/subtractor family.
// Holds the serial FSM state encoding and the default operand width.
package adders_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per cycle, with a valid/ready handshake on both sides.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import adders_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             d_bit, br_bit;
  logic             accept, last_bit;

  full_subtractor u_cell (
    .a    (a_reg[cnt_reg]),
    .b    (b_reg[cnt_reg]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (br_bit)
  );

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Partial result accumulates in res_reg; diff only updates on the final bit,
  // so it keeps the previous result visible until the new one is complete.
  always_comb begin
    res_next          = res_reg;
    res_next[cnt_reg] = d_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
      br_reg  <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      cnt_reg <= '0;
      br_reg  <= 1'b0;
    end else if (state_reg == RUN) begin
      res_reg <= res_next;
      cnt_reg <= cnt_reg + 1'b1;
      br_reg  <= br_bit;
      if (last_bit) begin
        diff <= res_next;
        bout <= br_bit;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: operand signs differ and the result sign departs from a.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state_reg == RUN && last_bit) begin
      ovf <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_bit != a_reg[WIDTH-1]);
    end
  end
`endif

endmodule
